// File: rtl/wr_valid_gen_pkg.sv
// Shared definitions for the FIFO write/read stimulus generators:
// state encodings and default FIFO geometry.
package wr_valid_gen_pkg;

  localparam int unsigned DEF_FIFO_DEPTH    = 8;
  localparam int unsigned DEF_COUNTER_WIDTH = 3;
  localparam int unsigned GAP_CNT_WIDTH     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/wr_valid_gen.sv
// Write-side FIFO stimulus generator: bursts of FIFO_DEPTH writes with an
// incrementing payload, stalling on full, separated by a fixed idle gap.
//
//   state | meaning
//   IDLE  | waiting for enable to start a burst
//   BURST | offering writes until FIFO_DEPTH have been accepted
//   GAP   | GAP_CYCLES idle cycles, then burst again or go idle
module wr_valid_gen
  import wr_valid_gen_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned GAP_CYCLES    = 4
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  full,
  output logic                  wr_valid,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_accept,
  output logic                  burst_done
);

  localparam logic [COUNTER_WIDTH-1:0] BURST_LAST = COUNTER_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [GAP_CNT_WIDTH-1:0] GAP_LAST   = GAP_CNT_WIDTH'(GAP_CYCLES - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [COUNTER_WIDTH-1:0]   r_burst_cnt;
  logic [GAP_CNT_WIDTH-1:0]   r_gap_cnt;
  logic [DATA_WIDTH-1:0]      r_wr_data;
  logic                       r_wr_valid;
  logic                       r_burst_done;
  logic                       w_accept;
  logic                       w_burst_term;
  logic                       w_gap_term;

  assign w_accept     = r_wr_valid & ~full;
  assign w_burst_term = w_accept && (r_burst_cnt == BURST_LAST);
  assign w_gap_term   = (r_gap_cnt == GAP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (enable)       w_state_nxt = ST_BURST;
      ST_BURST: if (w_burst_term) w_state_nxt = ST_GAP;
      ST_GAP:   if (w_gap_term)   w_state_nxt = enable ? ST_BURST : ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_wr_valid   <= 1'b0;
      r_burst_done <= 1'b0;
      r_burst_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_valid   <= (w_state_nxt == ST_BURST);
      r_burst_done <= w_burst_term;
      if (w_accept) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
        r_wr_data   <= r_wr_data + 1'b1;
      end
      // Counts only while staying in GAP, so every entry starts from zero.
      if ((r_state == ST_GAP) && (w_state_nxt == ST_GAP))
        r_gap_cnt <= r_gap_cnt + 1'b1;
      else
        r_gap_cnt <= '0;
    end
  end

  assign wr_valid   = r_wr_valid;
  assign wr_data    = r_wr_data;
  assign wr_accept  = w_accept;
  assign burst_done = r_burst_done;

endmodule
